// File: rtl/dmem_if.sv
// Request/response bundle between the memory FU (master) and the data memory (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [2:0]  bhw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        finish;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, bhw, addr, wdata, input busy, finish, rdata, err);
  modport slave  (input req, we, bhw, addr, wdata, output busy, finish, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: one load/store in flight, RISC-V B/H/W access with
// sign/zero extension, one-cycle finish pulse, misaligned/illegal width flagged.
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic              op_we;
  logic [2:0]        op_bhw;
  logic [ADDR_W+1:0] op_addr;
  logic [31:0]       op_wdata;

  logic              cur_we;
  logic [2:0]        cur_bhw;
  logic [ADDR_W+1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rword, sh, ld, wdat;
  logic [3:0]        wmask;
  logic              bad, enter_resp;
  logic [31:0]       rdata_q;
  logic              err_q;

  // upper address bits alias onto the same words
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:ADDR_W+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (bus.req) begin
        if (LATENCY == 1) state_n = RESP;
        else begin
          state_n = WAIT;
          cnt_n   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt_n == '0) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we    <= 1'b0;
      op_bhw   <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (state == IDLE && bus.req) begin
      op_we    <= bus.we;
      op_bhw   <= bus.bhw;
      op_addr  <= bus.addr[ADDR_W+1:0];
      op_wdata <= bus.wdata;
    end
  end

  // With LATENCY=1 the memory access happens on the accept edge itself,
  // so the live bus fields are used while still in IDLE.
  always_comb begin
    cur_we    = (state == IDLE) ? bus.we    : op_we;
    cur_bhw   = (state == IDLE) ? bus.bhw   : op_bhw;
    cur_addr  = (state == IDLE) ? bus.addr[ADDR_W+1:0] : op_addr;
    cur_wdata = (state == IDLE) ? bus.wdata : op_wdata;
  end

  assign widx  = cur_addr[ADDR_W+1:2];
  assign lane  = cur_addr[1:0];
  assign rword = mem[widx];
  assign sh    = rword >> {lane, 3'b000};

  always_comb begin
    bad = 1'b0;
    case (cur_bhw)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = cur_addr[0];
      3'b010:         bad = |cur_addr[1:0];
      default:        bad = 1'b1;
    endcase
    if (cur_we && cur_bhw[2]) bad = 1'b1;
  end

  always_comb begin
    ld = rword;
    case (cur_bhw)
      3'b000:  ld = {{24{sh[7]}},  sh[7:0]};
      3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld = {24'd0, sh[7:0]};
      3'b101:  ld = {16'd0, sh[15:0]};
      default: ld = rword;
    endcase
  end

  always_comb begin
    wmask = 4'hF;
    wdat  = cur_wdata;
    case (cur_bhw[1:0])
      2'b00: begin
        wmask = 4'b0001 << lane;
        wdat  = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << {lane[1], 1'b0};
        wdat  = {2{cur_wdata[15:0]}};
      end
      default: begin
        wmask = 4'hF;
        wdat  = cur_wdata;
      end
    endcase
  end

  assign enter_resp = (state != RESP) && (state_n == RESP);

  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !bad && !rst) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (cur_we || bad) ? 32'd0 : ld;
      err_q   <= bad;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.finish = (state == RESP);
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized check of dmem_responder against a byte-level memory model.
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int AW  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [31:0] mref [0:(1<<AW)-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: access size from funct3, alignment by modulo,
  // bytes gathered one at a time and extended arithmetically.
  function automatic void model(input logic we, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int size, idx, lane;
    logic [31:0] v;
    size = 1 << int'(f[1:0]);
    idx  = int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    lane = int'(a & 32'd3);
    e    = (f[1:0] == 2'd3) || (f[2] && (f[1:0] == 2'd2 || we)) || ((a % 32'(size)) != 0);
    rd   = 32'd0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < size; i++) mref[idx][8*(lane+i) +: 8] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mref[idx][8*(lane+i) +: 8];
      if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endfunction

  // Issue one request from an idle cycle; report latency (cycle index of finish
  // after the accept edge, 0 = never) plus the response. hold keeps req high
  // while busy with scrambled fields, which must be ignored.
  task automatic txn(input logic we, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold,
                     output logic [31:0] rd, output logic e, output int lat);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.req = 1'b1; bus.we = we; bus.bhw = f; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    if (!hold) bus.req = 1'b0;
    bus.we = 1'($urandom); bus.bhw = 3'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= LAT + 8; n++) begin
      if (bus.finish) begin lat = n; break; end
      if (n == 1) chk("wait_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    rd = bus.rdata;
    e  = bus.err;
    @(posedge clk); #1;
    chk("pulse_end", 32'(bus.finish), 32'd0);
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input bit hold, output logic [31:0] rd, output logic e);
    logic [31:0] erd;
    logic ee;
    int lat;
    model(we, f, a, wd, erd, ee);
    txn(we, f, a, wd, hold, rd, e, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_err"}, 32'(e), 32'(ee));
    chk({tag, "_rd"}, rd, erd);
  endtask

  task automatic count_finish(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.finish) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic e;
    logic [2:0] f;
    int cnt;

    for (int i = 0; i < (1 << AW); i++) mref[i] = 32'd0;
    bus.req = 1'b0; bus.we = 1'b0; bus.bhw = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_finish", 32'(bus.finish), 32'd0);
    chk("rst_rdata",  bus.rdata,       32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, e);
    run("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e);
    chk("lw10_val", rd, 32'hDEADBEEF);

    run("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, e);
    chk("lb13_val", rd, 32'hFFFFFFDE);
    run("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, e);
    chk("lbu13_val", rd, 32'h000000DE);
    run("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, e);
    chk("lh12_val", rd, 32'hFFFFDEAD);
    run("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, rd, e);
    chk("lhu10_val", rd, 32'h0000BEEF);

    run("sb11", 1'b1, 3'b000, 32'h11, 32'h12345655, 1'b0, rd, e);
    run("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, e);
    chk("lw10b_val", rd, 32'hDEAD55EF);
    run("lw1010", 1'b0, 3'b010, 32'h1010, 32'h0, 1'b0, rd, e);
    chk("alias_val", rd, 32'hDEAD55EF);

    run("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 1'b0, rd, e);
    chk("lw12_err", 32'(e), 32'd1);
    run("sh11", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 1'b0, rd, e);
    chk("sh11_err", 32'(e), 32'd1);
    run("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, e);
    chk("lw10c_val", rd, 32'hDEAD55EF);
    count_finish(4, cnt);
    chk("busy_req_ignored", 32'(cnt), 32'd0);

    // async reset in an idle cycle while rdata holds a nonzero value
    #2 rst = 1'b1;
    #1;
    chk("arst_rdata",  bus.rdata,       32'd0);
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_finish", 32'(bus.finish), 32'd0);
    chk("arst_err",    32'(bus.err),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run("sw20z", 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, rd, e);
    bus.req = 1'b1; bus.we = 1'b1; bus.bhw = 3'b010; bus.addr = 32'h20; bus.wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.req = 1'b0;
    #1 rst = 1'b1;
    #1 chk("abort_busy", 32'(bus.busy), 32'd0);
    #3 rst = 1'b0;
    count_finish(5, cnt);
    chk("abort_nofinish", 32'(cnt), 32'd0);
    run("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, e);
    chk("lw20_val", rd, 32'h00000000);

    for (int w = 0; w < 16; w++)
      run("fill", 1'b1, 3'b010, 32'(w) << 2, $urandom, 1'b0, rd, e);
    for (int k = 0; k < 200; k++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run("rnd", 1'($urandom), f, a, $urandom, 1'($urandom_range(0, 3) == 0), rd, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
